bus_arbiter: RTL

Two-master round-robin arbiter with a watchdog for the native valid/ready memory bus. It sits between two requesters (m0: CPU data port, m1: firmware loader/debug port) and one downstream slave path (RAM/IO decode). It serialises transactions and holds each grant until the slave answers. It aborts any transaction the slave does not answer within a bounded number of cycles, so a missing peripheral cannot hang the core.

---
 rtl/bus_arbiter_pkg.sv | 23 ++
 rtl/bus_watchdog.sv | 39 +++
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the native valid/ready memory bus arbiter:
// FSM encoding, bus field widths, request payload and abort data default.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter for the arbiter watchdog; flags expiry when the
// count reaches TIMEOUT-1. TIMEOUT=0 disables expiry entirely.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus. Holds each grant
// until the slave answers, or completes the transfer itself on watchdog expiry.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT      = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant,
  output logic              busy,
  input  logic              err_clr,
  output logic              bus_error,
  output logic [ADDR_W-1:0] err_addr
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              bus_error_q, bus_error_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic     wd_clear, wd_enable, wd_expired;
  logic     done_c;
  bus_req_t m0_req, m1_req, sel_req;

  assign m0_req  = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req  = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign sel_req = grant_q ? m1_req : m0_req;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Next state: on a tie the master that did not win last time is granted.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d  = (m0_valid && m1_valid) ? ~last_q : m1_valid;
          last_d   = grant_d;
          wd_clear = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          state_d = ST_IDLE;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            state_d = ST_ABORT;
          end
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are a combinational function of state, grant and slave reply.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_rdata = '0;
    busy    = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      ST_BUSY: begin
        busy    = 1'b1;
        s_valid = 1'b1;
        s_addr  = sel_req.addr;
        s_wdata = sel_req.wdata;
        s_wstrb = sel_req.wstrb;
        if (s_ready) begin
          done_c  = 1'b1;
          m_rdata = s_rdata;
        end
      end
      ST_ABORT: begin
        busy    = 1'b1;
        done_c  = 1'b1;
        m_rdata = TIMEOUT_DATA;
      end
      default: ;
    endcase
  end

  assign m0_ready = done_c && !grant_q;
  assign m1_ready = done_c && grant_q;

  // Abort beats a simultaneous clear, and then reloads the captured address.
  always_comb begin
    bus_error_d = bus_error_q;
    err_addr_d  = err_addr_q;
    if (state_q == ST_ABORT) begin
      bus_error_d = 1'b1;
      if (!bus_error_q || err_clr) begin
        err_addr_d = sel_req.addr;
      end
    end else if (err_clr) begin
      bus_error_d = 1'b0;
    end
  end

  assign grant     = grant_q;
  assign bus_error = bus_error_q;
  assign err_addr  = err_addr_q;

endmodule
